// File: rtl/stage_4_mem.sv
// Memory-access stage and MEM/WB pipeline register: issues data-bus loads/stores,
// aligns and extends load data, stalls upstream while a bus access is outstanding.
module stage_4_mem #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        cpu_clk,
    input  logic        reset_n,
    input  logic        enb_4,
    input  logic [31:0] ALU_OUT_rg3,
    input  logic [31:0] data_R2_rg3,
    input  logic        RWBEn_rg3,
    input  logic        MEMRW_rg3,
    input  logic [2:0]  func_3_rg3,
    input  logic [4:0]  rd_rg3,
    input  logic [1:0]  WBSel_rg3,
    input  logic [31:0] count_rg3,
    input  logic [31:0] instt3,
    output logic        dbus_valid,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_ready,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic        stall_mem,
    output logic [31:0] ALU_OUT_rg4,
    output logic [31:0] load_data_rg4,
    output logic [31:0] count_rg4,
    output logic [31:0] instt4,
    output logic [4:0]  rd_rg4,
    output logic [1:0]  WBSel_rg4,
    output logic        RWBEn_rg4,
    output logic        misalign_rg4,
    output logic        bus_err_rg4
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               mem_op, misalign, bad_op, good_op;
    logic               commit, abort, timed_out;
    logic [31:0]        issue_wdata;
    logic [3:0]         issue_be;
    logic               req_we;
    logic [31:0]        req_addr, req_wdata;
    logic [3:0]         req_be;
    logic [2:0]         ld_f3;
    logic [1:0]         ld_lo;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        ld_ext;

    // Operation decode, alignment check and store lane replication
    always_comb begin
        mem_op = enb_4 & (MEMRW_rg3 | (WBSel_rg3 == 2'b10));
        case (func_3_rg3)
            3'b000, 3'b100: misalign = 1'b0;
            3'b001, 3'b101: misalign = ALU_OUT_rg3[0];
            3'b010:         misalign = |ALU_OUT_rg3[1:0];
            default:        misalign = 1'b1;
        endcase
        bad_op  = mem_op & misalign;
        good_op = mem_op & ~misalign;

        issue_be    = 4'b1111;
        issue_wdata = data_R2_rg3;
        if (MEMRW_rg3) begin
            case (func_3_rg3[1:0])
                2'b00: begin
                    issue_be    = 4'(4'b0001 << ALU_OUT_rg3[1:0]);
                    issue_wdata = {4{data_R2_rg3[7:0]}};
                end
                2'b01: begin
                    issue_be    = ALU_OUT_rg3[1] ? 4'b1100 : 4'b0011;
                    issue_wdata = {2{data_R2_rg3[15:0]}};
                end
                default: begin
                    issue_be    = 4'b1111;
                    issue_wdata = data_R2_rg3;
                end
            endcase
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state, bus request and stall; IDLE drives straight from the inputs
    always_comb begin
        state_nxt  = state;
        commit     = 1'b0;
        abort      = 1'b0;
        stall_mem  = 1'b0;
        dbus_valid = 1'b0;
        dbus_we    = req_we;
        dbus_addr  = req_addr;
        dbus_wdata = req_wdata;
        dbus_be    = req_be;
        timed_out  = (cnt == CNT_W'(TIMEOUT - 1));
        case (state)
            IDLE: begin
                dbus_we    = MEMRW_rg3;
                dbus_addr  = {ALU_OUT_rg3[31:2], 2'b00};
                dbus_wdata = issue_wdata;
                dbus_be    = issue_be;
                if (good_op) begin
                    dbus_valid = 1'b1;
                    if (dbus_ready && MEMRW_rg3) begin
                        commit = 1'b1;
                    end else begin
                        state_nxt = dbus_ready ? RESP : REQ;
                        stall_mem = 1'b1;
                    end
                end
            end
            REQ: begin
                dbus_valid = 1'b1;
                stall_mem  = 1'b1;
                if (dbus_ready) begin
                    if (req_we) begin
                        state_nxt = IDLE;
                        commit    = 1'b1;
                        stall_mem = 1'b0;
                    end else begin
                        state_nxt = RESP;
                    end
                end else if (timed_out) begin
                    state_nxt = IDLE;
                    commit    = 1'b1;
                    abort     = 1'b1;
                    stall_mem = 1'b0;
                end
            end
            RESP: begin
                stall_mem = 1'b1;
                if (dbus_rvalid || timed_out) begin
                    state_nxt = IDLE;
                    commit    = 1'b1;
                    abort     = ~dbus_rvalid;
                    stall_mem = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!reset_n) begin
            state_nxt  = IDLE;
            commit     = 1'b0;
            abort      = 1'b0;
            stall_mem  = 1'b0;
            dbus_valid = 1'b0;
        end
    end

    // Timeout counter: restarts on every state change, counts while waiting
    always_ff @(posedge cpu_clk) begin
        if (!reset_n || state_nxt != state || state_nxt == IDLE) cnt <= '0;
        else                                                     cnt <= cnt + CNT_W'(1);
    end

    // Request and load-format capture when leaving IDLE
    always_ff @(posedge cpu_clk) begin
        if (!reset_n) begin
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
            ld_f3     <= '0;
            ld_lo     <= '0;
        end else if (state == IDLE && state_nxt != IDLE) begin
            req_we    <= MEMRW_rg3;
            req_addr  <= {ALU_OUT_rg3[31:2], 2'b00};
            req_wdata <= issue_wdata;
            req_be    <= issue_be;
            ld_f3     <= func_3_rg3;
            ld_lo     <= ALU_OUT_rg3[1:0];
        end
    end

    // Load lane select and sign/zero extension
    always_comb begin
        case (ld_lo)
            2'd0:    ld_byte = dbus_rdata[7:0];
            2'd1:    ld_byte = dbus_rdata[15:8];
            2'd2:    ld_byte = dbus_rdata[23:16];
            default: ld_byte = dbus_rdata[31:24];
        endcase
        ld_half = ld_lo[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        case (ld_f3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = dbus_rdata;
        endcase
    end

    // MEM/WB register; stalls and disabled cycles insert a bubble carrying the PC
    always_ff @(posedge cpu_clk) begin
        if (!reset_n) begin
            ALU_OUT_rg4   <= '0;
            load_data_rg4 <= '0;
            count_rg4     <= '0;
            instt4        <= '0;
            rd_rg4        <= '0;
            WBSel_rg4     <= '0;
            RWBEn_rg4     <= 1'b0;
            misalign_rg4  <= 1'b0;
            bus_err_rg4   <= 1'b0;
        end else if (stall_mem || (!commit && !enb_4)) begin
            ALU_OUT_rg4   <= '0;
            load_data_rg4 <= '0;
            count_rg4     <= count_rg3;
            instt4        <= '0;
            rd_rg4        <= '0;
            WBSel_rg4     <= '0;
            RWBEn_rg4     <= 1'b0;
            misalign_rg4  <= 1'b0;
            bus_err_rg4   <= 1'b0;
        end else begin
            ALU_OUT_rg4   <= ALU_OUT_rg3;
            load_data_rg4 <= (commit && !abort && state == RESP) ? ld_ext : 32'd0;
            count_rg4     <= count_rg3;
            instt4        <= instt3;
            rd_rg4        <= rd_rg3;
            WBSel_rg4     <= WBSel_rg3;
            RWBEn_rg4     <= RWBEn_rg3 & ~abort & ~(bad_op & ~commit);
            misalign_rg4  <= bad_op & ~commit;
            bus_err_rg4   <= abort;
        end
    end

endmodule

// File: tb/tb_stage_4_mem.sv
// Bench for stage_4_mem: table of ALU/load/store operations against a small bus
// responder, writeback results scoreboarded, plus reset and enable sequences.
module tb_stage_4_mem;

    localparam int unsigned TO = 64;
    localparam int NEVER = 100000;
    localparam int K_ALU = 0;
    localparam int K_LD  = 1;
    localparam int K_ST  = 2;

    logic        cpu_clk, reset_n, enb_4;
    logic [31:0] ALU_OUT_rg3, data_R2_rg3, count_rg3, instt3;
    logic        RWBEn_rg3, MEMRW_rg3;
    logic [2:0]  func_3_rg3;
    logic [4:0]  rd_rg3;
    logic [1:0]  WBSel_rg3;
    logic        dbus_valid, dbus_we, dbus_ready, dbus_rvalid;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;
    logic        stall_mem;
    logic [31:0] ALU_OUT_rg4, load_data_rg4, count_rg4, instt4;
    logic [4:0]  rd_rg4;
    logic [1:0]  WBSel_rg4;
    logic        RWBEn_rg4, misalign_rg4, bus_err_rg4;

    stage_4_mem #(.TIMEOUT(TO)) dut (
        .cpu_clk(cpu_clk), .reset_n(reset_n), .enb_4(enb_4),
        .ALU_OUT_rg3(ALU_OUT_rg3), .data_R2_rg3(data_R2_rg3), .RWBEn_rg3(RWBEn_rg3),
        .MEMRW_rg3(MEMRW_rg3), .func_3_rg3(func_3_rg3), .rd_rg3(rd_rg3),
        .WBSel_rg3(WBSel_rg3), .count_rg3(count_rg3), .instt3(instt3),
        .dbus_valid(dbus_valid), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_ready(dbus_ready),
        .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata), .stall_mem(stall_mem),
        .ALU_OUT_rg4(ALU_OUT_rg4), .load_data_rg4(load_data_rg4), .count_rg4(count_rg4),
        .instt4(instt4), .rd_rg4(rd_rg4), .WBSel_rg4(WBSel_rg4), .RWBEn_rg4(RWBEn_rg4),
        .misalign_rg4(misalign_rg4), .bus_err_rg4(bus_err_rg4)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        int          kind;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          rlat;
        int          vlat;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ld;
        logic        mis;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] alu, ld, cnt, ins;
        logic [4:0]  rd;
        logic [1:0]  wbs;
        logic        rwb, mis, err;
    } wb_t;

    vec_t vt[16];
    wb_t  sb_q[$];
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] rg4_or();
        return ALU_OUT_rg4 | load_data_rg4 | instt4
             | 32'({rd_rg4, WBSel_rg4, RWBEn_rg4, misalign_rg4, bus_err_rg4});
    endfunction

    task automatic run_op(input vec_t v, input int idx);
        wb_t  e;
        wb_t  g;
        int   stalls = 0;
        int   acc = -1;
        int   exp_st = 0;
        logic seen = 1'b0;
        logic done = 1'b0;
        logic stall_now, vld_now;

        enb_4       = 1'b1;
        ALU_OUT_rg3 = v.addr;
        data_R2_rg3 = v.data;
        func_3_rg3  = v.f3;
        rd_rg3      = 5'(idx + 1);
        count_rg3   = 32'h1000 + 32'(idx * 4);
        instt3      = 32'hA000_0000 | 32'(idx);
        MEMRW_rg3   = (v.kind == K_ST);
        WBSel_rg3   = (v.kind == K_LD) ? 2'b10 : (v.kind == K_ST) ? 2'b00 : 2'b01;
        RWBEn_rg3   = (v.kind != K_ST);

        e.alu = v.addr; e.ld = v.ld; e.cnt = count_rg3; e.ins = instt3;
        e.rd = rd_rg3; e.wbs = WBSel_rg3; e.mis = v.mis; e.err = v.err;
        e.rwb = RWBEn_rg3 & ~v.mis & ~v.err;
        sb_q.push_back(e);

        if (!v.mis && v.kind == K_ST) exp_st = (v.rlat >= NEVER) ? TO : v.rlat;
        if (!v.mis && v.kind == K_LD) exp_st = v.rlat + ((v.vlat >= NEVER) ? TO : v.vlat);

        for (int c = 0; c < 400; c++) begin
            dbus_ready  = (c >= v.rlat);
            dbus_rvalid = (acc >= 0) && (c == acc + v.vlat);
            dbus_rdata  = dbus_rvalid ? v.rdata : 32'h5A5A_5A5A;
            #1;
            if (dbus_valid && !seen) begin
                seen = 1'b1;
                chk($sformatf("op%0d addr", idx), dbus_addr, {v.addr[31:2], 2'b00});
                chk($sformatf("op%0d we", idx), 32'(dbus_we), 32'(v.kind == K_ST));
                chk($sformatf("op%0d be", idx), 32'(dbus_be), 32'(v.be));
                if (v.kind == K_ST) chk($sformatf("op%0d wdata", idx), dbus_wdata, v.wdata);
            end
            stall_now = stall_mem;
            vld_now   = dbus_valid;
            @(posedge cpu_clk);
            #1;
            if (vld_now && dbus_ready && acc < 0) acc = c;
            if (!stall_now) begin
                done = 1'b1;
                break;
            end
            stalls++;
            chk($sformatf("op%0d bubble_cnt", idx), count_rg4, count_rg3);
            chk($sformatf("op%0d bubble_zero", idx), rg4_or(), 32'd0);
            @(negedge cpu_clk);
        end

        chk($sformatf("op%0d completed", idx), 32'(done), 32'd1);
        chk($sformatf("op%0d stall_cycles", idx), 32'(stalls), 32'(exp_st));
        chk($sformatf("op%0d valid_seen", idx), 32'(seen), 32'(v.kind != K_ALU && !v.mis));
        if (sb_q.size() == 0) begin
            chk($sformatf("op%0d sb_nonempty", idx), 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            g.alu = ALU_OUT_rg4; g.ld = load_data_rg4; g.cnt = count_rg4; g.ins = instt4;
            g.rd = rd_rg4; g.wbs = WBSel_rg4; g.rwb = RWBEn_rg4;
            g.mis = misalign_rg4; g.err = bus_err_rg4;
            chk($sformatf("op%0d alu_rg4", idx), g.alu, e.alu);
            chk($sformatf("op%0d load_data_rg4", idx), g.ld, e.ld);
            chk($sformatf("op%0d count_rg4", idx), g.cnt, e.cnt);
            chk($sformatf("op%0d instt4", idx), g.ins, e.ins);
            chk($sformatf("op%0d rd/wbsel", idx), 32'({g.rd, g.wbs}), 32'({e.rd, e.wbs}));
            chk($sformatf("op%0d rwb/mis/err", idx), 32'({g.rwb, g.mis, g.err}),
                32'({e.rwb, e.mis, e.err}));
        end
        @(negedge cpu_clk);
        dbus_ready  = 1'b0;
        dbus_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // kind f3 addr data rdata rlat vlat be wdata ld mis err
        vt[0]  = '{K_ALU, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0};
        vt[1]  = '{K_ST, 3'b000, 32'h0000_0103, 32'hAB, 32'h0, 0, 0, 4'h8, 32'hABAB_ABAB, 32'h0, 1'b0, 1'b0};
        vt[2]  = '{K_LD, 3'b000, 32'h0000_0102, 32'h0, 32'h0080_0000, 0, 3, 4'hF, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0};
        vt[3]  = '{K_LD, 3'b100, 32'h0000_0102, 32'h0, 32'h0080_0000, 0, 3, 4'hF, 32'h0, 32'h0000_0080, 1'b0, 1'b0};
        vt[4]  = '{K_LD, 3'b010, 32'h0000_0202, 32'h0, 32'h0, 0, 0, 4'hF, 32'h0, 32'h0, 1'b1, 1'b0};
        vt[5]  = '{K_ST, 3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0, NEVER, 0, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1};
        vt[6]  = '{K_ST, 3'b001, 32'h0000_0106, 32'h1234_BEEF, 32'h0, 2, 0, 4'hC, 32'hBEEF_BEEF, 32'h0, 1'b0, 1'b0};
        vt[7]  = '{K_LD, 3'b001, 32'h0000_0106, 32'h0, 32'h8001_7FFF, 1, 2, 4'hF, 32'h0, 32'hFFFF_8001, 1'b0, 1'b0};
        vt[8]  = '{K_LD, 3'b101, 32'h0000_0104, 32'h0, 32'h8001_F00D, 0, 1, 4'hF, 32'h0, 32'h0000_F00D, 1'b0, 1'b0};
        vt[9]  = '{K_LD, 3'b010, 32'h0000_0208, 32'h0, 32'hDEAD_BEEF, 0, 1, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vt[10] = '{K_LD, 3'b000, 32'h0000_0101, 32'h0, 32'h1234_5678, 0, 2, 4'hF, 32'h0, 32'h0000_0056, 1'b0, 1'b0};
        vt[11] = '{K_ST, 3'b001, 32'h0000_0101, 32'h1111, 32'h0, 0, 0, 4'hF, 32'h0, 32'h0, 1'b1, 1'b0};
        vt[12] = '{K_LD, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 4'hF, 32'h0, 32'h0, 1'b1, 1'b0};
        vt[13] = '{K_LD, 3'b010, 32'h0000_040C, 32'h0, 32'h0, 0, NEVER, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1};
        vt[14] = '{K_ST, 3'b010, 32'h0000_0404, 32'hCAFE_F00D, 32'h0, 0, 0, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0};
        vt[15] = '{K_LD, 3'b100, 32'h0000_0103, 32'h0, 32'hFF00_0000, 1, 1, 4'hF, 32'h0, 32'h0000_00FF, 1'b0, 1'b0};

        // Reset with an aligned load presented: no request, no stall, empty MEM/WB
        reset_n = 1'b0; enb_4 = 1'b1;
        ALU_OUT_rg3 = 32'h10; data_R2_rg3 = 32'h0; RWBEn_rg3 = 1'b1; MEMRW_rg3 = 1'b0;
        func_3_rg3 = 3'b010; rd_rg3 = 5'd3; WBSel_rg3 = 2'b10;
        count_rg3 = 32'h44; instt3 = 32'h0000_2003;
        dbus_ready = 1'b1; dbus_rvalid = 1'b0; dbus_rdata = 32'h0;
        @(negedge cpu_clk);
        #1;
        chk("reset valid", 32'(dbus_valid), 32'd0);
        chk("reset stall", 32'(stall_mem), 32'd0);
        @(posedge cpu_clk);
        #1;
        chk("reset rg4_zero", rg4_or(), 32'd0);
        chk("reset count_rg4", count_rg4, 32'd0);
        @(negedge cpu_clk);
        reset_n = 1'b1;
        dbus_ready = 1'b0;

        // enb_4=0 with a load present: bubble, no request
        enb_4 = 1'b0; count_rg3 = 32'h777;
        #1;
        chk("enb0 valid", 32'(dbus_valid), 32'd0);
        chk("enb0 stall", 32'(stall_mem), 32'd0);
        @(posedge cpu_clk);
        #1;
        chk("enb0 count_rg4", count_rg4, 32'h777);
        chk("enb0 rg4_zero", rg4_or(), 32'd0);
        @(negedge cpu_clk);

        for (int i = 0; i < 16; i++) run_op(vt[i], i);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        // LH sitting in RESP, reset for one cycle, then a stray rvalid
        enb_4 = 1'b1; ALU_OUT_rg3 = 32'h100; func_3_rg3 = 3'b001; MEMRW_rg3 = 1'b0;
        WBSel_rg3 = 2'b10; RWBEn_rg3 = 1'b1; rd_rg3 = 5'd7; count_rg3 = 32'h88;
        instt3 = 32'h0000_1083; dbus_ready = 1'b1;
        @(posedge cpu_clk);
        #1;
        chk("lh stall_resp", 32'(stall_mem), 32'd1);
        @(negedge cpu_clk);
        reset_n = 1'b0; dbus_ready = 1'b0;
        #1;
        chk("midreset valid", 32'(dbus_valid), 32'd0);
        chk("midreset stall", 32'(stall_mem), 32'd0);
        @(posedge cpu_clk);
        #1;
        chk("midreset rg4_zero", rg4_or() | count_rg4, 32'd0);
        @(negedge cpu_clk);
        reset_n = 1'b1; WBSel_rg3 = 2'b01; ALU_OUT_rg3 = 32'h55; rd_rg3 = 5'd9;
        dbus_rvalid = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
        #1;
        chk("stray stall", 32'(stall_mem), 32'd0);
        chk("stray valid", 32'(dbus_valid), 32'd0);
        @(posedge cpu_clk);
        #1;
        chk("stray load_data", load_data_rg4, 32'd0);
        chk("stray alu_rg4", ALU_OUT_rg4, 32'h55);
        chk("stray rd/rwb", 32'({rd_rg4, RWBEn_rg4, bus_err_rg4}), 32'({5'd9, 1'b1, 1'b0}));
        @(negedge cpu_clk);
        dbus_rvalid = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
